// File: rtl/uart_frame_receiver.sv
// uart_frame_receiver
//
// Rebuilds one 20-bit message from three back-to-back 10-bit serial characters
// (start 0, 8 data bits LSB-first, stop 1; line idles high).
//   char 0 -> message[19:12], char 1 -> message[11:4],
//   char 2 -> {message[3:0], 4'b0000} (first four data bits on the wire are pad).
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high
//   serialIn      asynchronous serial line, idle high
//   message       last good message, held until the next good frame
//   messageValid  one-cycle pulse when message updates
//   framingError  one-cycle pulse when a frame is discarded
//   busy          high from the first start edge until the frame completes or aborts
//
// Optional feature: define RX_PAD_CHECK_EN to reject frames whose char-2 pad
// nibble is not zero. Without it the pad bits are ignored.

module uart_frame_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned GAP_TIMEOUT  = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serialIn,
    output logic [19:0] message,
    output logic        messageValid,
    output logic        framingError,
    output logic        busy
);

    localparam int unsigned HALF    = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_MAX = (CLKS_PER_BIT > GAP_TIMEOUT) ? CLKS_PER_BIT : GAP_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        StHunt,
        StIdle,
        StStart,
        StData,
        StStop,
        StGap,
        StDone
    } state_e;

    state_e           state;
    logic             rx_meta;
    logic             rxs;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [1:0]       char_idx;
    logic [7:0]       shift;
    logic [7:0]       byte0;
    logic [7:0]       byte1;

    always_ff @(posedge clock) begin
        if (reset) begin
            // Synchronizer resets to the idle level so reset never looks like a start edge.
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            state        <= StHunt;
            cnt          <= '0;
            bit_cnt      <= '0;
            char_idx     <= '0;
            shift        <= '0;
            byte0        <= '0;
            byte1        <= '0;
            message      <= '0;
            messageValid <= 1'b0;
            framingError <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_meta      <= serialIn;
            rxs          <= rx_meta;
            messageValid <= 1'b0;
            framingError <= 1'b0;

            unique case (state)
                // Require a full bit time of idle before trusting any falling edge.
                StHunt: begin
                    if (!rxs) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StIdle: begin
                    if (!rxs) begin
                        state    <= StStart;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        char_idx <= '0;
                    end
                end

                StStart: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt <= '0;
                        if (rxs) begin
                            if (char_idx == 2'd0) begin
                                // Glitch before any character: quietly drop it.
                                state <= StIdle;
                                busy  <= 1'b0;
                            end else begin
                                framingError <= 1'b1;
                                busy         <= 1'b0;
                                state        <= StHunt;
                            end
                        end else begin
                            bit_cnt <= '0;
                            state   <= StData;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StData: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        shift <= {rxs, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= StStop;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StStop: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt <= '0;
                        if (!rxs) begin
                            framingError <= 1'b1;
                            busy         <= 1'b0;
                            state        <= StHunt;
                        end else if (char_idx == 2'd2) begin
                            state <= StDone;
                        end else begin
                            if (char_idx == 2'd0) begin
                                byte0 <= shift;
                            end else begin
                                byte1 <= shift;
                            end
                            char_idx <= char_idx + 2'd1;
                            state    <= StGap;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Each character resyncs on its own start edge.
                StGap: begin
                    if (!rxs) begin
                        cnt   <= '0;
                        state <= StStart;
                    end else if (cnt == CNT_W'(GAP_TIMEOUT - 1)) begin
                        cnt          <= '0;
                        framingError <= 1'b1;
                        busy         <= 1'b0;
                        state        <= StHunt;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StDone: begin
                    busy <= 1'b0;
`ifdef RX_PAD_CHECK_EN
                    if (shift[3:0] != 4'b0000) begin
                        framingError <= 1'b1;
                        cnt          <= '0;
                        state        <= StHunt;
                    end else begin
                        message      <= {byte0, byte1, shift[7:4]};
                        messageValid <= 1'b1;
                        state        <= StIdle;
                    end
`else
                    message      <= {byte0, byte1, shift[7:4]};
                    messageValid <= 1'b1;
                    state        <= StIdle;
`endif
                end

                default: begin
                    state <= StHunt;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver with default parameters
// (CLKS_PER_BIT=10, GAP_TIMEOUT=20). Inputs change on the falling edge; outputs
// are sampled on the falling edge. A line change driven just after rising edge P
// reaches rxs at edge P+2 and is acted on by the FSM at edge P+3 (= t0).

module tb_uart_frame_receiver;

    localparam int unsigned CPB = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic        serial_in;
    logic [19:0] message;
    logic        message_valid;
    logic        framing_error;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int both_cnt   = 0;

    int          v_cycs[$];
    logic [19:0] v_msgs[$];
    int          e_cycs[$];

    uart_frame_receiver #(
        .CLKS_PER_BIT(10),
        .GAP_TIMEOUT (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .serialIn    (serial_in),
        .message     (message),
        .messageValid(message_valid),
        .framingError(framing_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse log, sampled away from the active edge.
    always @(negedge clock) begin
        if (message_valid === 1'b1) begin
            v_cycs.push_back(cyc);
            v_msgs.push_back(message);
        end
        if (framing_error === 1'b1) e_cycs.push_back(cyc);
        if (message_valid === 1'b1 && framing_error === 1'b1) both_cnt++;
    end

    // Wire order: index 0 goes out first.
    function automatic logic [29:0] frame_bits(input logic [19:0] msg, input logic [3:0] pad);
        logic [7:0] b2;
        b2 = {msg[3:0], pad};
        return {1'b1, b2, 1'b0, 1'b1, msg[11:4], 1'b0, 1'b1, msg[19:12], 1'b0};
    endfunction

    task automatic send_bits(input logic [29:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            serial_in = w[i];
            repeat (CPB) @(negedge clock);
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_log();
        v_cycs.delete();
        v_msgs.delete();
        e_cycs.delete();
    endtask

    task automatic test_reset();
        serial_in = 1'b1;
        reset     = 1'b1;
        repeat (3) @(negedge clock);
        compared++;
        if (message !== 20'h0) begin
            mismatched++; $display("FAIL reset_message: got %h, expected 00000", message);
        end
        compared++;
        if (message_valid !== 1'b0) begin
            mismatched++; $display("FAIL reset_valid: got %b, expected 0", message_valid);
        end
        compared++;
        if (framing_error !== 1'b0) begin
            mismatched++; $display("FAIL reset_error: got %b, expected 0", framing_error);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        reset = 1'b0;
        idle(20);
    endtask

    task automatic test_single_frame();
        int start;
        clear_log();
        start = cyc;
        send_bits(frame_bits(20'hA5C3F, 4'h0), 30);
        idle(10);
        compared++;
        if (v_cycs.size() !== 1) begin
            mismatched++; $display("FAIL single_count: got %0d, expected 1", v_cycs.size());
        end
        if (v_cycs.size() >= 1) begin
            compared++;
            if (v_cycs[0] !== start + 299) begin
                mismatched++;
                $display("FAIL single_latency: got %0d, expected %0d", v_cycs[0] - start, 299);
            end
            compared++;
            if (v_msgs[0] !== 20'hA5C3F) begin
                mismatched++; $display("FAIL single_value: got %h, expected a5c3f", v_msgs[0]);
            end
        end
        compared++;
        if (e_cycs.size() !== 0) begin
            mismatched++; $display("FAIL single_error: got %0d pulses, expected 0", e_cycs.size());
        end
        compared++;
        if (message !== 20'hA5C3F || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL single_hold: got msg %h busy %b, expected a5c3f 0", message, busy);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        clear_log();
        start = cyc;
        send_bits(frame_bits(20'h00001, 4'h0), 30);
        send_bits(frame_bits(20'hFFFFF, 4'h0), 30);
        idle(10);
        compared++;
        if (v_cycs.size() !== 2) begin
            mismatched++; $display("FAIL b2b_count: got %0d, expected 2", v_cycs.size());
        end
        if (v_cycs.size() >= 2) begin
            compared++;
            if (v_cycs[0] !== start + 299 || v_cycs[1] - v_cycs[0] !== 300) begin
                mismatched++;
                $display("FAIL b2b_timing: got %0d and %0d, expected 299 and 599",
                         v_cycs[0] - start, v_cycs[1] - start);
            end
            compared++;
            if (v_msgs[0] !== 20'h00001 || v_msgs[1] !== 20'hFFFFF) begin
                mismatched++;
                $display("FAIL b2b_values: got %h %h, expected 00001 fffff", v_msgs[0], v_msgs[1]);
            end
        end
        compared++;
        if (e_cycs.size() !== 0) begin
            mismatched++; $display("FAIL b2b_error: got %0d pulses, expected 0", e_cycs.size());
        end
    endtask

    task automatic test_stop_error();
        int          start;
        bit          busy_hi;
        logic [29:0] w;
        clear_log();
        start = cyc;
        w     = frame_bits(20'h5A5A5, 4'h0);
        w[19] = 1'b0;
        send_bits(w, 20);
        idle(3);
        // Char-1 stop sample lands at t0+195.
        compared++;
        if (e_cycs.size() !== 1) begin
            mismatched++; $display("FAIL stop_err_count: got %0d, expected 1", e_cycs.size());
        end else begin
            compared++;
            if (e_cycs[0] !== start + 198) begin
                mismatched++;
                $display("FAIL stop_err_time: got %0d, expected 198", e_cycs[0] - start);
            end
        end
        compared++;
        if (v_cycs.size() !== 0 || message !== 20'hFFFFF || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL stop_err_state: got valids %0d msg %h busy %b, expected 0 fffff 0",
                     v_cycs.size(), message, busy);
        end
        // A short low while hunting must not open a frame.
        busy_hi   = 1'b0;
        serial_in = 1'b0;
        repeat (2) @(negedge clock);
        serial_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_hi = 1'b1;
        end
        compared++;
        if (busy_hi !== 1'b0) begin
            mismatched++; $display("FAIL hunt_busy: got %b, expected 0", busy_hi);
        end
        idle(20);
        clear_log();
        start = cyc;
        send_bits(frame_bits(20'h3C3C3, 4'h0), 30);
        idle(10);
        compared++;
        if (v_cycs.size() !== 1 || message !== 20'h3C3C3) begin
            mismatched++;
            $display("FAIL after_err_frame: got %0d valids msg %h, expected 1 3c3c3",
                     v_cycs.size(), message);
        end
    endtask

    task automatic test_gap_timeout();
        int start;
        clear_log();
        start = cyc;
        send_bits(frame_bits(20'hC0FFE, 4'h0), 10);
        idle(30);
        // Stop sample at start+98, timeout GAP_TIMEOUT clocks later.
        compared++;
        if (e_cycs.size() !== 1) begin
            mismatched++; $display("FAIL gap_err_count: got %0d, expected 1", e_cycs.size());
        end else begin
            compared++;
            if (e_cycs[0] !== start + 118) begin
                mismatched++;
                $display("FAIL gap_err_time: got %0d, expected 118", e_cycs[0] - start);
            end
        end
        compared++;
        if (v_cycs.size() !== 0 || busy !== 1'b0 || message !== 20'h3C3C3) begin
            mismatched++;
            $display("FAIL gap_state: got valids %0d busy %b msg %h, expected 0 0 3c3c3",
                     v_cycs.size(), busy, message);
        end
        idle(10);
    endtask

    task automatic test_glitch();
        clear_log();
        serial_in = 1'b0;
        repeat (3) @(negedge clock);
        serial_in = 1'b1;
        @(negedge clock);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++; $display("FAIL glitch_busy_set: got %b, expected 1", busy);
        end
        repeat (3) @(negedge clock);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++; $display("FAIL glitch_busy_hold: got %b, expected 1", busy);
        end
        @(negedge clock);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL glitch_busy_clear: got %b, expected 0", busy);
        end
        idle(20);
        compared++;
        if (v_cycs.size() !== 0 || e_cycs.size() !== 0) begin
            mismatched++;
            $display("FAIL glitch_pulses: got %0d valid %0d error, expected 0 0",
                     v_cycs.size(), e_cycs.size());
        end
    endtask

    task automatic test_reset_mid();
        int start;
        clear_log();
        send_bits(frame_bits(20'h0F0F0, 4'h0), 14);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++; $display("FAIL mid_busy: got %b, expected 1", busy);
        end
        reset     = 1'b1;
        serial_in = 1'b1;
        @(negedge clock);
        compared++;
        if (message !== 20'h0 || message_valid !== 1'b0 || framing_error !== 1'b0 ||
            busy !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_outputs: got %h %b %b %b, expected 00000 0 0 0",
                     message, message_valid, framing_error, busy);
        end
        reset = 1'b0;
        idle(20);
        start = cyc;
        send_bits(frame_bits(20'h12345, 4'h0), 30);
        idle(10);
        compared++;
        if (v_cycs.size() !== 1) begin
            mismatched++; $display("FAIL post_reset_count: got %0d, expected 1", v_cycs.size());
        end else begin
            compared++;
            if (v_msgs[0] !== 20'h12345 || v_cycs[0] !== start + 299) begin
                mismatched++;
                $display("FAIL post_reset_frame: got %h at %0d, expected 12345 at 299",
                         v_msgs[0], v_cycs[0] - start);
            end
        end
        compared++;
        if (e_cycs.size() !== 0) begin
            mismatched++; $display("FAIL post_reset_error: got %0d, expected 0", e_cycs.size());
        end
    endtask

    task automatic test_pad();
        int start;
        clear_log();
        start = cyc;
        send_bits(frame_bits(20'h6789A, 4'b0100), 30);
        idle(10);
`ifdef RX_PAD_CHECK_EN
        compared++;
        if (e_cycs.size() !== 1) begin
            mismatched++; $display("FAIL pad_err_count: got %0d, expected 1", e_cycs.size());
        end else begin
            compared++;
            if (e_cycs[0] !== start + 299) begin
                mismatched++;
                $display("FAIL pad_err_time: got %0d, expected 299", e_cycs[0] - start);
            end
        end
        compared++;
        if (v_cycs.size() !== 0 || message !== 20'h12345) begin
            mismatched++;
            $display("FAIL pad_reject: got %0d valids msg %h, expected 0 12345",
                     v_cycs.size(), message);
        end
`else
        compared++;
        if (v_cycs.size() !== 1 || message !== 20'h6789A) begin
            mismatched++;
            $display("FAIL pad_ignored: got %0d valids msg %h, expected 1 6789a",
                     v_cycs.size(), message);
        end
        compared++;
        if (e_cycs.size() !== 0) begin
            mismatched++; $display("FAIL pad_error: got %0d, expected 0", e_cycs.size());
        end
`endif
        idle(15);
    endtask

    task automatic test_exclusive();
        compared++;
        if (both_cnt !== 0) begin
            mismatched++; $display("FAIL valid_and_error: got %0d overlaps, expected 0", both_cnt);
        end
    endtask

    initial begin
        reset     = 1'b1;
        serial_in = 1'b1;
        @(negedge clock);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stop_error();
        test_gap_timeout();
        test_glitch();
        test_reset_mid();
        test_pad();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
